minrv32_seq: RTL and testbench
==============================

# minrv32_seq

Multicycle sequencer wrapping the combinational minrv32 datapath. It owns the architectural pc and the held instruction word, fetches instructions over a single shared memory bus, and runs the data phase the core requests for loads and stores. Each instruction commits with a one-cycle register-file write strobe, which lets the single-cycle core run against ordinary wait-stated memory. It sits between the core and the system bus, and it owns trap, halt and retire bookkeeping.

## Interface
- PROGADDR_RESET, 32'h0000_0000: pc value loaded on reset.
- WAIT_LIMIT, 8'd16: bus wait-cycle limit per transfer, range 1..255. A value of 0 disables the watchdog.
- clk, in, 1: the single clock. All state changes on its rising edge.
- resetn, in, 1: asynchronous, active-low reset.
- pc, out, 32: architectural pc, presented to the core.
- insn, out, 32: held instruction word, presented to the core.
- core_pc_next, in, 32: next pc computed by the core.
- core_trap, in, 1: the core flags insn as illegal.
- core_rd_valid, in, 1: the core intends an rd write.
- core_mem_valid, in, 1: the core requests a data access.
- core_mem_addr, in, 32: data access address from the core.
- core_mem_wdata, in, 32: store data from the core.
- core_mem_wstrb, in, 4: store byte strobes from the core.
- core_mem_rdata, out, 32: latched load data returned to the core.
- rf_we, out, 1: register-file write strobe, one cycle per commit.
- bus_valid, out, 1: bus request.
- bus_instr, out, 1: 1 = instruction fetch.
- bus_ready, in, 1: bus completion.
- bus_addr, out, 32: bus address.
- bus_wdata, out, 32: bus write data.
- bus_wstrb, out, 4: bus byte strobes; 0 = read.
- bus_rdata, in, 32: bus read data.
- halt_req, in, 1: request a stop at the next instruction boundary.
- halted, out, 1: high while in HALT.
- trap, out, 1: high while in TRAP.
- retire, out, 1: one-cycle pulse per retired instruction.
- instret, out, 32: count of retired instructions.

## Operation
- States: BOOT, FETCH, EXEC, MEM, WB, HALT, TRAP.
- Reset values: state BOOT, pc = PROGADDR_RESET, insn = 32'h0000_0013 (NOP), core_mem_rdata = 0, instret = 0, wait counter = 0.
  - Every combinational output is 0 during reset.
- BOOT: go to HALT if halt_req is high, else go to FETCH.
- FETCH: drive bus_valid=1, bus_instr=1, bus_addr=pc, bus_wstrb=0, bus_wdata=0.
  - On bus_ready: insn <= bus_rdata, go to EXEC.
- EXEC: the core evaluates insn; no bus activity.
  - If core_trap: go to TRAP.
  - Else if core_mem_valid: go to MEM.
  - Else commit.
- MEM: drive bus_valid=1, bus_instr=0, and pass core_mem_addr, core_mem_wdata and core_mem_wstrb through to the bus.
  - On bus_ready: core_mem_rdata <= bus_rdata, go to WB.
- WB: commit; the core now sees the latched load data.
- Commit, in EXEC or WB:
  - If core_pc_next[1:0] != 0: go to TRAP with no rf_we and pc unchanged.
  - Otherwise assert rf_we = core_rd_valid and retire = 1; pc <= core_pc_next; instret += 1 (wraps 32'hFFFF_FFFF to 0).
  - Next state is HALT if halt_req is high, else FETCH.
- HALT: halted=1, no bus activity. When halt_req is low, go to FETCH.
- TRAP: trap=1. Sticky until reset; no bus activity, no commits.
- Watchdog (WAIT_LIMIT != 0):
  - The counter clears on entry to FETCH or MEM.
  - It increments each cycle that bus_valid=1 and bus_ready=0.
  - If bus_ready is still low when the counter equals WAIT_LIMIT-1, go to TRAP; bus_valid drops on the next cycle.
- Precedence in EXEC: core_trap wins over core_mem_valid, which wins over halt_req.
- halt_req raised mid-instruction (FETCH, EXEC with a memory access, MEM) never aborts the instruction. The instruction completes, then the sequencer halts.

## Timing
- bus_ready is sampled on the rising edge while bus_valid=1. Zero-wait memory completes in the same cycle the request is presented.
- bus_addr, bus_wdata, bus_wstrb and bus_instr are stable from bus_valid rising until the cycle bus_ready is sampled high.
- Instruction latency with zero-wait memory:
  - Non-memory instruction: 2 cycles (FETCH, EXEC).
  - Load or store: 4 cycles (FETCH, EXEC, MEM, WB).
  - Each bus wait cycle adds 1.
- rf_we, retire, and the pc/instret updates all take effect on the same edge at the end of the commit cycle.
- Back-to-back instructions: FETCH of pc+4 begins the cycle immediately after commit.
- Reset asserted mid-transfer forces bus_valid=0 asynchronously, with no completion and no commit.

## Test plan
- Reset release, PROGADDR_RESET=0x100, zero-wait memory holding ADDI at 0x100 -> bus fetch at 0x100 on the cycle after BOOT; retire pulses at cycle 3; pc=0x104; instret=1.
- Store, with core_mem_addr=0x2000, wstrb=4'b1111, wdata=0xDEADBEEF, and 2 wait cycles on the data phase -> bus fields held for 3 cycles; rf_we=0; retire 6 cycles after the fetch starts.
- Load from 0x3000 returning 0x12345678, core_rd_valid=1 -> core_mem_rdata=0x12345678 in WB, with rf_we=1 for exactly one cycle.
- core_trap=1 in EXEC with halt_req=1 at the same time -> TRAP; trap stays 1 for 100 cycles; no bus_valid; instret unchanged.
- WAIT_LIMIT=4 and bus_ready held low -> TRAP after 4 request cycles; bus_valid=0 from the fifth cycle on.
- halt_req raised during MEM -> the instruction retires, then HALT with halted=1. Dropping halt_req -> the next cycle fetches from the new pc.

Source files
------------

// File: rtl/minrv32_seq.sv
// minrv32_seq: multicycle sequencer around the combinational minrv32 core.
// Holds the architectural pc and instruction word, fetches over a shared bus,
// runs the load/store data phase, and commits each instruction with a single
// rf_we/retire strobe. Also tracks halt, trap and the retired-instruction count.
//
// Ports:
//   clk, resetn                 clock, asynchronous active-low reset
//   pc, insn                    architectural pc and held instruction (to core)
//   core_pc_next, core_trap     next pc / illegal-instruction flag (from core)
//   core_rd_valid               core intends an rd write
//   core_mem_valid/addr/wdata/wstrb  data access request from the core
//   core_mem_rdata              latched load data (to core)
//   rf_we                       register-file write strobe, one cycle per commit
//   bus_valid/instr/addr/wdata/wstrb, bus_ready, bus_rdata   shared memory bus
//   halt_req, halted            stop request at instruction boundary / halted
//   trap                        sticky trap indicator
//   retire, instret             retire pulse and retired-instruction counter
module minrv32_seq #(
    parameter logic [31:0] PROGADDR_RESET = 32'h0000_0000,
    parameter logic [7:0]  WAIT_LIMIT     = 8'd16
) (
    input  logic        clk,
    input  logic        resetn,
    output logic [31:0] pc,
    output logic [31:0] insn,
    input  logic [31:0] core_pc_next,
    input  logic        core_trap,
    input  logic        core_rd_valid,
    input  logic        core_mem_valid,
    input  logic [31:0] core_mem_addr,
    input  logic [31:0] core_mem_wdata,
    input  logic [3:0]  core_mem_wstrb,
    output logic [31:0] core_mem_rdata,
    output logic        rf_we,
    output logic        bus_valid,
    output logic        bus_instr,
    input  logic        bus_ready,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic [31:0] bus_rdata,
    input  logic        halt_req,
    output logic        halted,
    output logic        trap,
    output logic        retire,
    output logic [31:0] instret
);

    typedef enum logic [2:0] {BOOT, FETCH, EXEC, MEM, WB, HALT, TRAP} state_t;

    state_t     state, state_nxt;
    logic [7:0] wait_cnt;
    logic       in_xfer;
    logic       do_commit;
    logic       misaligned;
    logic       commit_ok;
    logic       wd_expire;
    logic       entering_xfer;

    // Shared decision terms used by both the next-state and output logic.
    always_comb begin
        in_xfer       = (state == FETCH) || (state == MEM);
        do_commit     = ((state == EXEC) && !core_trap && !core_mem_valid) || (state == WB);
        misaligned    = (core_pc_next[1:0] != 2'b00);
        commit_ok     = do_commit && !misaligned;
        // Last tolerated wait cycle: a still-low ready here means the transfer is dead.
        wd_expire     = (WAIT_LIMIT != 8'd0) && in_xfer && !bus_ready &&
                        (wait_cnt == WAIT_LIMIT - 8'd1);
        entering_xfer = ((state_nxt == FETCH) || (state_nxt == MEM)) && (state_nxt != state);
    end

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= BOOT;
        else         state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            BOOT:  state_nxt = halt_req ? HALT : FETCH;
            FETCH: begin
                if (bus_ready)      state_nxt = EXEC;
                else if (wd_expire) state_nxt = TRAP;
            end
            EXEC: begin
                if (core_trap)           state_nxt = TRAP;
                else if (core_mem_valid) state_nxt = MEM;
                else if (misaligned)     state_nxt = TRAP;
                else                     state_nxt = halt_req ? HALT : FETCH;
            end
            MEM: begin
                if (bus_ready)      state_nxt = WB;
                else if (wd_expire) state_nxt = TRAP;
            end
            WB: begin
                if (misaligned) state_nxt = TRAP;
                else            state_nxt = halt_req ? HALT : FETCH;
            end
            HALT:    if (!halt_req) state_nxt = FETCH;
            TRAP:    state_nxt = TRAP;
            default: state_nxt = BOOT;
        endcase
    end

    // Output logic; reset forces state to BOOT asynchronously, so all of these drop at once.
    always_comb begin
        bus_valid = in_xfer;
        bus_instr = (state == FETCH);
        bus_addr  = '0;
        bus_wdata = '0;
        bus_wstrb = '0;
        if (state == FETCH) begin
            bus_addr = pc;
        end else if (state == MEM) begin
            bus_addr  = core_mem_addr;
            bus_wdata = core_mem_wdata;
            bus_wstrb = core_mem_wstrb;
        end
        rf_we  = commit_ok && core_rd_valid;
        retire = commit_ok;
        halted = (state == HALT);
        trap   = (state == TRAP);
    end

    // Architectural registers and watchdog counter
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc             <= PROGADDR_RESET;
            insn           <= 32'h0000_0013;
            core_mem_rdata <= '0;
            instret        <= '0;
            wait_cnt       <= '0;
        end else begin
            if ((state == FETCH) && bus_ready) insn <= bus_rdata;
            if ((state == MEM) && bus_ready)   core_mem_rdata <= bus_rdata;
            if (commit_ok) begin
                pc      <= core_pc_next;
                instret <= instret + 32'd1;
            end
            if (entering_xfer)                wait_cnt <= '0;
            else if (in_xfer && !bus_ready)   wait_cnt <= wait_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_minrv32_seq.sv
module tb_minrv32_seq;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] pc, insn, core_pc_next, core_mem_addr, core_mem_wdata, core_mem_rdata;
    logic        core_trap, core_rd_valid, core_mem_valid;
    logic [3:0]  core_mem_wstrb, bus_wstrb;
    logic        rf_we, bus_valid, bus_instr, bus_ready;
    logic [31:0] bus_addr, bus_wdata, bus_rdata, instret;
    logic        halt_req, halted, trap, retire;

    int n_cmp  = 0;
    int n_fail = 0;

    minrv32_seq #(.PROGADDR_RESET(32'h0000_0100), .WAIT_LIMIT(8'd4)) dut (
        .clk(clk), .resetn(resetn), .pc(pc), .insn(insn),
        .core_pc_next(core_pc_next), .core_trap(core_trap), .core_rd_valid(core_rd_valid),
        .core_mem_valid(core_mem_valid), .core_mem_addr(core_mem_addr),
        .core_mem_wdata(core_mem_wdata), .core_mem_wstrb(core_mem_wstrb),
        .core_mem_rdata(core_mem_rdata), .rf_we(rf_we), .bus_valid(bus_valid),
        .bus_instr(bus_instr), .bus_ready(bus_ready), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb), .bus_rdata(bus_rdata),
        .halt_req(halt_req), .halted(halted), .trap(trap), .retire(retire), .instret(instret)
    );

    initial forever #5 clk = ~clk;

    // Toy core: insn[1:0] kind (0 alu, 1 load, 2 store, 3 jump), insn[2] rd write,
    // insn[7:2]==6'h3F illegal, data addr insn[31:16], jump target insn[23:8].
    assign core_trap      = (insn[7:2] == 6'h3F);
    assign core_mem_valid = (insn[1:0] == 2'd1) || (insn[1:0] == 2'd2);
    assign core_mem_addr  = {16'h0, insn[31:16]};
    assign core_mem_wstrb = (insn[1:0] == 2'd2) ? insn[15:12] : 4'h0;
    assign core_mem_wdata = (insn[1:0] == 2'd2) ? (insn ^ pc ^ 32'h5A5A_0F0F) : 32'h0;
    assign core_rd_valid  = (insn[1:0] != 2'd2) && insn[2];
    assign core_pc_next   = (insn[1:0] == 2'd3) ? {16'h0, insn[23:8]} : pc + 32'd4;

    // Memory
    logic [31:0] imem [logic [31:0]];
    logic [31:0] dmem [logic [31:0]];
    int          wait_q[$];
    bit          stall;

    function automatic logic [31:0] imem_rd(input logic [31:0] a);
        return imem.exists(a) ? imem[a] : 32'h0000_0000;
    endfunction

    function automatic logic [31:0] dmem_rd(input logic [31:0] a);
        return dmem.exists(a) ? dmem[a] : ({a[15:0], ~a[15:0]} ^ 32'h1357_9BDF);
    endfunction

    // Bus responder: each transfer takes its wait count from wait_q (0 if empty).
    initial begin
        int  cur_wait;
        bit  busy;
        busy      = 1'b0;
        cur_wait  = 0;
        bus_ready = 1'b0;
        bus_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            if (!bus_valid) begin
                bus_ready = 1'b0;
                busy      = 1'b0;
            end else begin
                if (!busy) begin
                    busy     = 1'b1;
                    cur_wait = stall ? 1_000_000 : (wait_q.size() > 0 ? wait_q.pop_front() : 0);
                end
                if (cur_wait == 0) begin
                    bus_ready = 1'b1;
                    bus_rdata = bus_instr ? imem_rd(bus_addr) : dmem_rd(bus_addr);
                    busy      = 1'b0;
                end else begin
                    bus_ready = 1'b0;
                    cur_wait--;
                end
            end
        end
    end

    task automatic do_reset();
        resetn   = 1'b0;
        halt_req = 1'b0;
        stall    = 1'b0;
        wait_q.delete();
        imem.delete();
        dmem.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({pc, insn, instret, core_mem_rdata} !== {32'h100, 32'h13, 32'h0, 32'h0}) begin
            n_fail++;
            $display("FAIL reset_regs: pc=%h insn=%h instret=%h rdata=%h, want 100/13/0/0",
                     pc, insn, instret, core_mem_rdata);
        end
        n_cmp++;
        if ({bus_valid, bus_instr, rf_we, retire, halted, trap, bus_addr, bus_wdata, bus_wstrb} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: valid=%b instr=%b we=%b ret=%b hlt=%b trp=%b addr=%h, want all 0",
                     bus_valid, bus_instr, rf_we, retire, halted, trap, bus_addr);
        end
    endtask

    task automatic test_boot();
        do_reset();
        imem[32'h100] = 32'h0000_0004;
        resetn = 1'b1;
        #1;
        n_cmp++;
        if (bus_valid !== 1'b0) begin
            n_fail++; $display("FAIL boot_idle: bus_valid=%b, want 0", bus_valid);
        end
        @(negedge clk);
        n_cmp++;
        if ({bus_valid, bus_instr, bus_addr, bus_wstrb} !== {1'b1, 1'b1, 32'h100, 4'h0}) begin
            n_fail++;
            $display("FAIL boot_fetch: valid=%b instr=%b addr=%h wstrb=%h, want 1/1/100/0",
                     bus_valid, bus_instr, bus_addr, bus_wstrb);
        end
        @(negedge clk);
        n_cmp++;
        if ({retire, rf_we} !== 2'b11) begin
            n_fail++; $display("FAIL boot_retire: retire=%b rf_we=%b, want 1/1", retire, rf_we);
        end
        @(negedge clk);
        n_cmp++;
        if ({pc, instret, retire, bus_valid, bus_addr} !== {32'h104, 32'd1, 1'b0, 1'b1, 32'h104}) begin
            n_fail++;
            $display("FAIL boot_next: pc=%h instret=%0d retire=%b valid=%b addr=%h, want 104/1/0/1/104",
                     pc, instret, retire, bus_valid, bus_addr);
        end
    endtask

    // Store to 0x2000 with two data-phase wait cycles.
    task automatic test_store();
        logic [31:0] exp_wd;
        bit          ev;
        do_reset();
        imem[32'h100] = 32'h2000_F002;
        exp_wd = 32'h2000_F002 ^ 32'h100 ^ 32'h5A5A_0F0F;
        wait_q = '{0, 2};
        resetn = 1'b1;
        for (int c = 2; c <= 8; c++) begin
            @(negedge clk);
            ev = (c == 2) || (c >= 4 && c <= 6) || (c == 8);
            n_cmp++;
            if (bus_valid !== ev) begin
                n_fail++; $display("FAIL store_valid c%0d: bus_valid=%b, want %b", c, bus_valid, ev);
            end
            if (c >= 4 && c <= 6) begin
                n_cmp++;
                if ({bus_instr, bus_addr, bus_wdata, bus_wstrb} !== {1'b0, 32'h2000, exp_wd, 4'hF}) begin
                    n_fail++;
                    $display("FAIL store_fields c%0d: instr=%b addr=%h wdata=%h wstrb=%h, want 0/2000/%h/f",
                             c, bus_instr, bus_addr, bus_wdata, bus_wstrb, exp_wd);
                end
            end
            n_cmp++;
            if ({retire, rf_we} !== {(c == 7), 1'b0}) begin
                n_fail++;
                $display("FAIL store_commit c%0d: retire=%b rf_we=%b, want %b/0", c, retire, rf_we, (c == 7));
            end
        end
    endtask

    // Load from 0x3000 with one fetch wait cycle.
    task automatic test_load();
        do_reset();
        imem[32'h100] = 32'h3000_0005;
        dmem[32'h3000] = 32'h1234_5678;
        wait_q = '{1, 0};
        resetn = 1'b1;
        for (int c = 2; c <= 7; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({retire, rf_we} !== {(c == 6), (c == 6)}) begin
                n_fail++;
                $display("FAIL load_commit c%0d: retire=%b rf_we=%b, want %b", c, retire, rf_we, (c == 6));
            end
            if (c == 5) begin
                n_cmp++;
                if ({bus_valid, bus_instr, bus_addr, bus_wstrb} !== {1'b1, 1'b0, 32'h3000, 4'h0}) begin
                    n_fail++;
                    $display("FAIL load_bus: valid=%b instr=%b addr=%h wstrb=%h, want 1/0/3000/0",
                             bus_valid, bus_instr, bus_addr, bus_wstrb);
                end
            end
            if (c == 6) begin
                n_cmp++;
                if (core_mem_rdata !== 32'h1234_5678) begin
                    n_fail++; $display("FAIL load_rdata: got %h, want 12345678", core_mem_rdata);
                end
            end
            if (c == 7) begin
                n_cmp++;
                if ({pc, instret} !== {32'h104, 32'd1}) begin
                    n_fail++; $display("FAIL load_after: pc=%h instret=%0d, want 104/1", pc, instret);
                end
            end
        end
    endtask

    // halt_req raised while the load is in its data phase.
    task automatic test_halt_mid();
        do_reset();
        imem[32'h100] = 32'h3000_0005;
        imem[32'h104] = 32'h0000_0004;
        wait_q = '{0, 1, 0};
        resetn = 1'b1;
        for (int c = 2; c <= 10; c++) begin
            @(negedge clk);
            if (c == 4) begin
                n_cmp++;
                if ({bus_valid, bus_instr} !== 2'b10) begin
                    n_fail++; $display("FAIL halt_in_mem: valid=%b instr=%b, want 1/0", bus_valid, bus_instr);
                end
                halt_req = 1'b1;
            end
            if (c == 6) begin
                n_cmp++;
                if ({retire, halted} !== 2'b10) begin
                    n_fail++; $display("FAIL halt_retire: retire=%b halted=%b, want 1/0", retire, halted);
                end
            end
            if (c >= 7 && c <= 9) begin
                n_cmp++;
                if ({halted, bus_valid, retire} !== 3'b100) begin
                    n_fail++;
                    $display("FAIL halt_hold c%0d: halted=%b valid=%b retire=%b, want 1/0/0",
                             c, halted, bus_valid, retire);
                end
                if (c == 9) halt_req = 1'b0;
            end
            if (c == 10) begin
                n_cmp++;
                if ({bus_valid, bus_instr, bus_addr, halted, instret} !== {1'b1, 1'b1, 32'h104, 1'b0, 32'd1}) begin
                    n_fail++;
                    $display("FAIL halt_resume: valid=%b instr=%b addr=%h halted=%b instret=%0d, want 1/1/104/0/1",
                             bus_valid, bus_instr, bus_addr, halted, instret);
                end
            end
        end
    endtask

    // Illegal instruction (which also requests a load) with halt_req high in EXEC.
    task automatic test_trap();
        do_reset();
        imem[32'h100] = 32'h0000_00FD;
        resetn = 1'b1;
        @(negedge clk);
        halt_req = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({retire, rf_we, bus_valid} !== 3'b000) begin
            n_fail++; $display("FAIL trap_exec: retire=%b rf_we=%b valid=%b, want 0", retire, rf_we, bus_valid);
        end
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({trap, bus_valid, retire, halted, instret} !== {4'b1000, 32'd0}) begin
                n_fail++;
                $display("FAIL trap_sticky c%0d: trap=%b valid=%b retire=%b halted=%b instret=%0d, want 1/0/0/0/0",
                         c, trap, bus_valid, retire, halted, instret);
            end
        end
        halt_req = 1'b0;
    endtask

    // Jump to an unaligned target.
    task automatic test_misaligned();
        do_reset();
        imem[32'h100] = 32'h0001_0203;
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({retire, rf_we} !== 2'b00) begin
            n_fail++; $display("FAIL misalign_commit: retire=%b rf_we=%b, want 0/0", retire, rf_we);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({trap, bus_valid, pc, instret} !== {2'b10, 32'h100, 32'd0}) begin
                n_fail++;
                $display("FAIL misalign_trap c%0d: trap=%b valid=%b pc=%h instret=%0d, want 1/0/100/0",
                         c, trap, bus_valid, pc, instret);
            end
        end
    endtask

    task automatic test_watchdog();
        int nvalid;
        bit seen_trap;
        do_reset();
        stall  = 1'b1;
        resetn = 1'b1;
        nvalid = 0;
        seen_trap = 1'b0;
        for (int c = 2; c <= 14; c++) begin
            @(negedge clk);
            if (bus_valid === 1'b1) nvalid++;
            if (trap === 1'b1) seen_trap = 1'b1;
            if (seen_trap) begin
                n_cmp++;
                if (bus_valid !== 1'b0) begin
                    n_fail++; $display("FAIL wd_drop c%0d: bus_valid=%b, want 0", c, bus_valid);
                end
            end
        end
        n_cmp++;
        if ({nvalid, trap} !== {32'd4, 1'b1}) begin
            n_fail++; $display("FAIL wd_count: valid_cycles=%0d trap=%b, want 4/1", nvalid, trap);
        end
        stall = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        stall  = 1'b1;
        resetn = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (bus_valid !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_pre: bus_valid=%b, want 1", bus_valid);
        end
        #2 resetn = 1'b0;
        #1;
        n_cmp++;
        if ({bus_valid, retire, pc, instret, core_mem_rdata} !== {2'b00, 32'h100, 32'd0, 32'd0}) begin
            n_fail++;
            $display("FAIL rstmid_async: valid=%b retire=%b pc=%h instret=%0d rdata=%h, want 0/0/100/0/0",
                     bus_valid, retire, pc, instret, core_mem_rdata);
        end
        stall = 1'b0;
    endtask

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ldata;
        logic        rdv;
        logic        is_load;
        int          rcyc;
    } exp_t;

    typedef struct {
        logic        instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } xfer_t;

    // Random program with random wait states; model predicts transfers, commit cycles and final pc.
    task automatic test_random();
        localparam int N = 60;
        exp_t        exp_q[$];
        xfer_t       xq[$];
        exp_t        e;
        xfer_t       x, xe;
        logic [31:0] mpc, mi, r, a, final_pc;
        int          kind, fw, dw, mcyc, cyc, idx;
        bit          pend;
        xfer_t       prev;

        do_reset();
        for (int k = 0; k < 64; k++) begin
            r = $urandom;
            kind = $urandom_range(0, 3);
            mi = r;
            mi[1:0] = 2'(kind);
            mi[7] = 1'b0;
            if (kind == 3) mi[23:8] = 16'(32'h100 + 4 * $urandom_range(0, 63));
            if (kind == 2 && mi[15:12] == 4'h0) mi[12] = 1'b1;
            imem[32'h100 + 32'(4 * k)] = mi;
        end

        mpc = 32'h100;
        mcyc = 1;
        for (int k = 0; k < N; k++) begin
            mi = imem_rd(mpc);
            kind = int'(mi[1:0]);
            a = {16'h0, mi[31:16]};
            fw = $urandom_range(0, 2);
            wait_q.push_back(fw);
            xq.push_back('{1'b1, mpc, 32'h0, 4'h0});
            e.pc = mpc;
            e.rdv = (kind != 2) && mi[2];
            e.is_load = (kind == 1);
            e.ldata = dmem_rd(a);
            mcyc += 2 + fw;
            if (kind == 1 || kind == 2) begin
                dw = $urandom_range(0, 2);
                wait_q.push_back(dw);
                mcyc += 2 + dw;
                if (kind == 1) xq.push_back('{1'b0, a, 32'h0, 4'h0});
                else           xq.push_back('{1'b0, a, mi ^ mpc ^ 32'h5A5A_0F0F, mi[15:12]});
            end
            e.rcyc = mcyc;
            exp_q.push_back(e);
            mpc = (kind == 3) ? {16'h0, mi[23:8]} : mpc + 32'd4;
        end
        final_pc = mpc;

        resetn = 1'b1;
        cyc  = 1;
        idx  = 0;
        pend = 1'b0;
        prev = '{1'b0, 32'h0, 32'h0, 4'h0};
        while (idx < N && cyc < mcyc + 20) begin
            @(negedge clk);
            cyc++;
            x = '{bus_instr, bus_addr, bus_wdata, bus_wstrb};
            if (pend) begin
                n_cmp++;
                if (bus_valid !== 1'b1 || x != prev) begin
                    n_fail++;
                    $display("FAIL rnd_stable c%0d: valid=%b addr=%h wdata=%h wstrb=%h, want held %h/%h/%h",
                             cyc, bus_valid, bus_addr, bus_wdata, bus_wstrb, prev.addr, prev.wdata, prev.wstrb);
                end
            end
            if (bus_valid === 1'b1 && bus_ready === 1'b1) begin
                n_cmp++;
                if (xq.size() == 0) begin
                    n_fail++; $display("FAIL rnd_xfer c%0d: unexpected transfer addr=%h", cyc, bus_addr);
                end else begin
                    xe = xq.pop_front();
                    if (x != xe) begin
                        n_fail++;
                        $display("FAIL rnd_xfer c%0d: instr=%b addr=%h wdata=%h wstrb=%h, want %b/%h/%h/%h",
                                 cyc, bus_instr, bus_addr, bus_wdata, bus_wstrb,
                                 xe.instr, xe.addr, xe.wdata, xe.wstrb);
                    end
                end
            end
            pend = (bus_valid === 1'b1) && (bus_ready !== 1'b1);
            prev = x;
            n_cmp++;
            if ({trap, halted, rf_we & ~retire} !== 3'b000) begin
                n_fail++;
                $display("FAIL rnd_status c%0d: trap=%b halted=%b rf_we=%b retire=%b, want no trap/halt/stray we",
                         cyc, trap, halted, rf_we, retire);
            end
            if (retire === 1'b1) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (cyc != e.rcyc || pc !== e.pc || rf_we !== e.rdv || instret !== 32'(idx)) begin
                    n_fail++;
                    $display("FAIL rnd_retire #%0d: cyc=%0d pc=%h rf_we=%b instret=%0d, want %0d/%h/%b/%0d",
                             idx, cyc, pc, rf_we, instret, e.rcyc, e.pc, e.rdv, idx);
                end
                if (e.is_load) begin
                    n_cmp++;
                    if (core_mem_rdata !== e.ldata) begin
                        n_fail++;
                        $display("FAIL rnd_load #%0d: rdata=%h, want %h", idx, core_mem_rdata, e.ldata);
                    end
                end
                idx++;
            end
        end
        n_cmp++;
        if (idx != N) begin
            n_fail++; $display("FAIL rnd_timeout: retired %0d, want %0d", idx, N);
        end
        @(negedge clk);
        n_cmp++;
        if ({pc, instret} !== {final_pc, 32'(N)}) begin
            n_fail++;
            $display("FAIL rnd_final: pc=%h instret=%0d, want %h/%0d", pc, instret, final_pc, N);
        end
    endtask

    initial begin
        resetn   = 1'b0;
        halt_req = 1'b0;
        stall    = 1'b0;
        test_reset();
        test_boot();
        test_store();
        test_load();
        test_halt_mid();
        test_trap();
        test_misaligned();
        test_watchdog();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
